// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file.
//   One byte-enabled write port, NRD registered read ports (latency 1),
//   optional read-during-write bypass, and a sequenced clear engine that
//   zeroes one entry per cycle for DEPTH cycles.
// Ports:
//   clk, rst (async, active-low)
//   clr_req  : one-cycle clear request; busy high while the clear runs
//   wr_en/wr_addr/wr_data/wr_be : write port, byte enable k covers byte k
//   rd_en/rd_addr : per-port read request, packed addresses (slice i = port i)
//   rd_data/rd_valid : packed registered read data, one-cycle valid pulse
//   err      : one-cycle pulse after any out-of-range access
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR   = 4,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR-1:0]       wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [WIDTH/8-1:0]    wr_be,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR-1:0]   rd_addr,
  output logic [NRD*WIDTH-1:0]  rd_data,
  output logic [NRD-1:0]        rd_valid,
  output logic                  err
);

  localparam int NBYTE = WIDTH / 8;
  // One extra bit so DEPTH itself (e.g. 256 with ADDR=8) is representable.
  localparam logic [ADDR:0]   DEPTH_L = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST_L  = ADDR'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR-1:0]     cnt_r;
  logic [ADDR-1:0]     cnt_next_s;
  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic                busy_r;
  logic                err_r;
  logic [NRD*WIDTH-1:0] rd_data_r;
  logic [NRD-1:0]      rd_valid_r;

  logic                idle_s;
  logic                wr_ok_s;
  logic                wr_oor_s;
  logic [ADDR-1:0]     rd_addr_s [NRD];
  logic [NRD-1:0]      rd_oor_s;
  logic [WIDTH-1:0]    rd_word_s [NRD];

  // Byte-merge: bytes with be[k]=1 come from new_w, the rest from old_w.
  function automatic logic [WIDTH-1:0] byte_merge(
    input logic [WIDTH-1:0] old_w,
    input logic [WIDTH-1:0] new_w,
    input logic [NBYTE-1:0] be
  );
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < NBYTE; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_w[8*k +: 8];
      end
    end
    return res;
  endfunction

  assign idle_s   = (state_r == IDLE);
  assign wr_ok_s  = idle_s && wr_en && ({1'b0, wr_addr} < DEPTH_L);
  assign wr_oor_s = wr_en && ({1'b0, wr_addr} >= DEPTH_L);

  // Clear sequencer next-state: walks cnt over 0..DEPTH-1, then back to IDLE.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_next_s = CLEAR;
          cnt_next_s   = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      CLEAR: begin
        // clr_req is not looked at here, so a request mid-clear is ignored.
        if (cnt_r == LAST_L) begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + ADDR'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Clear sequencer state, counter and registered busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= (state_next_s == CLEAR);
    end
  end

  // Per-port read word: zero when out of range, merged write data on a
  // same-address write when bypass is enabled, otherwise the stored entry.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_addr_s[i] = rd_addr[i*ADDR +: ADDR];
      rd_oor_s[i]  = ({1'b0, rd_addr_s[i]} >= DEPTH_L);
      if (rd_oor_s[i]) begin
        rd_word_s[i] = '0;
      end else if ((BYPASS != 0) && wr_ok_s && (wr_addr == rd_addr_s[i])) begin
        rd_word_s[i] = byte_merge(mem_r[rd_addr_s[i]], wr_data, wr_be);
      end else begin
        rd_word_s[i] = mem_r[rd_addr_s[i]];
      end
    end
  end

  // Storage array: clear engine has priority; writes only land in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (state_r == CLEAR) begin
      mem_r[cnt_r] <= '0;
    end else if (wr_ok_s) begin
      mem_r[wr_addr] <= byte_merge(mem_r[wr_addr], wr_data, wr_be);
    end
  end

  // Registered read outputs and error pulse; reads are ignored while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r  <= '0;
      rd_valid_r <= '0;
      err_r      <= 1'b0;
    end else begin
      err_r <= idle_s && (wr_oor_s || (|(rd_en & rd_oor_s)));
      for (int i = 0; i < NRD; i++) begin
        rd_valid_r[i] <= idle_s && rd_en[i];
        if (idle_s && rd_en[i]) begin
          rd_data_r[i*WIDTH +: WIDTH] <= rd_word_s[i];
        end
      end
    end
  end

  assign busy     = busy_r;
  assign err      = err_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp. Instance A uses defaults (DEPTH=16, BYPASS=1);
// instance B uses DEPTH=12, BYPASS=0 for the out-of-range and old-data cases.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_clr, a_busy, a_wr_en, a_err;
  logic [3:0]  a_wr_addr, a_wr_be;
  logic [31:0] a_wr_data;
  logic [1:0]  a_rd_en, a_rd_valid;
  logic [7:0]  a_rd_addr;
  logic [63:0] a_rd_data;

  logic        b_clr, b_busy, b_wr_en, b_err;
  logic [3:0]  b_wr_addr, b_wr_be;
  logic [31:0] b_wr_data;
  logic [1:0]  b_rd_en, b_rd_valid;
  logic [7:0]  b_rd_addr;
  logic [63:0] b_rd_data;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] m_a [16];
  logic [31:0] m_b [12];
  logic [31:0] held_a [2];
  int total = 0;
  int bad   = 0;

  regfile_mp #(.WIDTH(32), .DEPTH(16), .ADDR(4), .NRD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .clr_req(a_clr), .busy(a_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .err(a_err)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(12), .ADDR(4), .NRD(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .clr_req(b_clr), .busy(b_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .err(b_err)
  );

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_clr = 1'b0; a_wr_en = 1'b0; a_wr_addr = 4'd0; a_wr_data = 32'd0; a_wr_be = 4'd0;
    a_rd_en = 2'b00; a_rd_addr = 8'd0;
    b_clr = 1'b0; b_wr_en = 1'b0; b_wr_addr = 4'd0; b_wr_data = 32'd0; b_wr_be = 4'd0;
    b_rd_en = 2'b00; b_rd_addr = 8'd0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 16; i++) m_a[i] = 32'd0;
    for (int i = 0; i < 12; i++) m_b[i] = 32'd0;
    held_a[0] = 32'd0; held_a[1] = 32'd0;
    repeat (2) tick();
    total++;
    if ({a_busy, a_err, a_rd_valid, a_rd_data} !== 68'd0) begin
      bad++; $display("FAIL reset_a: got %h expected 0", {a_busy, a_err, a_rd_valid, a_rd_data});
    end
    total++;
    if ({b_busy, b_err, b_rd_valid, b_rd_data} !== 68'd0) begin
      bad++; $display("FAIL reset_b: got %h expected 0", {b_busy, b_err, b_rd_valid, b_rd_data});
    end
    #2 rst = 1'b1;
    tick();
    a_rd_en = 2'b11; a_rd_addr = {4'd15, 4'd0};
    q_a.push_back('{0, m_a[0]}); q_a.push_back('{1, m_a[15]});
    tick();
    a_rd_en = 2'b00;
    while (q_a.size() > 0) begin
      e = q_a.pop_front(); total++;
      if (a_rd_valid[e.port] !== 1'b1 || a_rd_data[e.port*32 +: 32] !== e.data) begin
        bad++; $display("FAIL reset_read p%0d: valid=%b data=%h expected 1/%h", e.port,
                        a_rd_valid[e.port], a_rd_data[e.port*32 +: 32], e.data);
      end
      held_a[e.port] = e.data;
    end
    total++;
    if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", a_err); end
    tick();
    total++;
    if (a_rd_valid !== 2'b00) begin
      bad++; $display("FAIL valid_pulse: got %b expected 00", a_rd_valid);
    end
  endtask

  task automatic test_byte_write();
    exp_t e;
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 32'hDEADBEEF; a_wr_be = 4'b1111;
    tick();
    a_wr_data = 32'h11223344; a_wr_be = 4'b0101;
    tick();
    a_wr_en = 1'b0;
    m_a[3] = 32'hDE22BE44;
    a_rd_en = 2'b10; a_rd_addr = {4'd3, 4'd0};
    q_a.push_back('{1, 32'hDE22BE44});
    tick();
    a_rd_en = 2'b00;
    total++;
    if (a_rd_valid !== 2'b10) begin bad++; $display("FAIL bw_valid: got %b expected 10", a_rd_valid); end
    while (q_a.size() > 0) begin
      e = q_a.pop_front(); total++;
      if (a_rd_valid[e.port] !== 1'b1 || a_rd_data[e.port*32 +: 32] !== e.data) begin
        bad++; $display("FAIL byte_write p%0d: data=%h expected %h", e.port,
                        a_rd_data[e.port*32 +: 32], e.data);
      end
      held_a[e.port] = e.data;
    end
  endtask

  task automatic test_rdw();
    exp_t e;
    a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 32'hAAAAAAAA; a_wr_be = 4'hF;
    b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = 32'hAAAAAAAA; b_wr_be = 4'hF;
    tick();
    a_wr_data = 32'h12345678; a_wr_be = 4'b0011;
    b_wr_data = 32'h12345678; b_wr_be = 4'b0011;
    a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd5};
    b_rd_en = 2'b01; b_rd_addr = {4'd0, 4'd5};
    q_a.push_back('{0, 32'hAAAA5678});
    q_b.push_back('{0, 32'hAAAAAAAA});
    m_a[5] = 32'hAAAA5678; m_b[5] = 32'hAAAA5678;
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      a_wr_en = 1'b0; b_wr_en = 1'b0;
      while (q_a.size() > 0) begin
        e = q_a.pop_front(); total++;
        if (a_rd_valid[e.port] !== 1'b1 || a_rd_data[e.port*32 +: 32] !== e.data) begin
          bad++; $display("FAIL rdw_a%0d p%0d: data=%h expected %h", pass, e.port,
                          a_rd_data[e.port*32 +: 32], e.data);
        end
        held_a[e.port] = e.data;
      end
      while (q_b.size() > 0) begin
        e = q_b.pop_front(); total++;
        if (b_rd_valid[e.port] !== 1'b1 || b_rd_data[e.port*32 +: 32] !== e.data) begin
          bad++; $display("FAIL rdw_b%0d p%0d: data=%h expected %h", pass, e.port,
                          b_rd_data[e.port*32 +: 32], e.data);
        end
      end
      // Follow-up read on both ports of the same address.
      a_rd_en = 2'b11; a_rd_addr = {4'd5, 4'd5};
      b_rd_en = 2'b11; b_rd_addr = {4'd5, 4'd5};
      if (pass == 0) begin
        q_a.push_back('{0, m_a[5]}); q_a.push_back('{1, m_a[5]});
        q_b.push_back('{0, m_b[5]}); q_b.push_back('{1, m_b[5]});
      end else begin
        a_rd_en = 2'b00; b_rd_en = 2'b00;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic        we;
    logic [3:0]  wa, be, ra;
    logic [31:0] wd, ex;
    logic [1:0]  ren;
    logic [7:0]  rad;
    logic        exp_err_b;
    logic [1:0]  exp_val_a, exp_val_b;
    for (int c = 0; c < 40; c++) begin
      // Instance A: full range, bypass.
      we = 1'($urandom_range(0, 1)); wa = 4'($urandom_range(0, 15));
      wd = $urandom; be = 4'($urandom_range(0, 15));
      ren = 2'($urandom_range(0, 3)); rad = 8'($urandom_range(0, 255));
      a_wr_en = we; a_wr_addr = wa; a_wr_data = wd; a_wr_be = be;
      a_rd_en = ren; a_rd_addr = rad; exp_val_a = ren;
      for (int p = 0; p < 2; p++) begin
        if (ren[p]) begin
          ra = rad[p*4 +: 4];
          ex = m_a[ra];
          if (we && wa == ra) ex = bmerge(ex, wd, be);
          q_a.push_back('{p, ex});
        end
      end
      if (we) m_a[wa] = bmerge(m_a[wa], wd, be);
      // Instance B: DEPTH 12, no bypass, addresses 12..15 out of range.
      we = 1'($urandom_range(0, 1)); wa = 4'($urandom_range(0, 15));
      wd = $urandom; be = 4'($urandom_range(0, 15));
      ren = 2'($urandom_range(0, 3)); rad = 8'($urandom_range(0, 255));
      b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_wr_be = be;
      b_rd_en = ren; b_rd_addr = rad; exp_val_b = ren;
      exp_err_b = we && (wa >= 4'd12);
      for (int p = 0; p < 2; p++) begin
        if (ren[p]) begin
          ra = rad[p*4 +: 4];
          if (ra >= 4'd12) begin
            exp_err_b = 1'b1;
            q_b.push_back('{p, 32'd0});
          end else begin
            q_b.push_back('{p, m_b[ra]});
          end
        end
      end
      if (we && wa < 4'd12) m_b[wa] = bmerge(m_b[wa], wd, be);
      tick();
      total++;
      if (a_rd_valid !== exp_val_a || a_err !== 1'b0) begin
        bad++; $display("FAIL b2b_a_ctl c%0d: valid=%b err=%b expected %b/0", c, a_rd_valid, a_err, exp_val_a);
      end
      total++;
      if (b_rd_valid !== exp_val_b || b_err !== exp_err_b) begin
        bad++; $display("FAIL b2b_b_ctl c%0d: valid=%b err=%b expected %b/%b", c, b_rd_valid, b_err,
                        exp_val_b, exp_err_b);
      end
      while (q_a.size() > 0) begin
        e = q_a.pop_front(); total++;
        if (a_rd_data[e.port*32 +: 32] !== e.data) begin
          bad++; $display("FAIL b2b_a c%0d p%0d: data=%h expected %h", c, e.port,
                          a_rd_data[e.port*32 +: 32], e.data);
        end
        held_a[e.port] = e.data;
      end
      while (q_b.size() > 0) begin
        e = q_b.pop_front(); total++;
        if (b_rd_data[e.port*32 +: 32] !== e.data) begin
          bad++; $display("FAIL b2b_b c%0d p%0d: data=%h expected %h", c, e.port,
                          b_rd_data[e.port*32 +: 32], e.data);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_out_of_range();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      b_wr_en = 1'b1; b_wr_addr = 4'(i); b_wr_data = 32'hB0000000 + 32'(i); b_wr_be = 4'hF;
      m_b[i] = 32'hB0000000 + 32'(i);
      tick();
    end
    b_wr_addr = 4'd13; b_wr_data = 32'h5;
    tick();
    b_wr_en = 1'b0;
    total++;
    if (b_err !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b expected 1", b_err); end
    tick();
    total++;
    if (b_err !== 1'b0) begin bad++; $display("FAIL oor_err_pulse: got %b expected 0", b_err); end
    b_rd_en = 2'b11; b_rd_addr = {4'd7, 4'd13};
    q_b.push_back('{0, 32'd0}); q_b.push_back('{1, m_b[7]});
    tick();
    total++;
    if (b_err !== 1'b1) begin bad++; $display("FAIL oor_rd_err: got %b expected 1", b_err); end
    for (int i = 0; i <= 6; i++) begin
      while (q_b.size() > 0) begin
        e = q_b.pop_front(); total++;
        if (b_rd_valid[e.port] !== 1'b1 || b_rd_data[e.port*32 +: 32] !== e.data) begin
          bad++; $display("FAIL oor_read s%0d p%0d: valid=%b data=%h expected 1/%h", i, e.port,
                          b_rd_valid[e.port], b_rd_data[e.port*32 +: 32], e.data);
        end
      end
      if (i < 6) begin
        b_rd_en = 2'b11; b_rd_addr = {4'(2*i+1), 4'(2*i)};
        q_b.push_back('{0, m_b[2*i]}); q_b.push_back('{1, m_b[2*i+1]});
        tick();
        total++;
        if (b_err !== 1'b0) begin bad++; $display("FAIL oor_inrange_err s%0d: got %b expected 0", i, b_err); end
      end
    end
    b_rd_en = 2'b00;
  endtask

  task automatic test_clear();
    exp_t e;
    int n;
    for (int i = 0; i < 16; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 4'(i); a_wr_data = 32'h0101_0101 * 32'(i + 1); a_wr_be = 4'hF;
      tick();
    end
    a_wr_en = 1'b0;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    for (int i = 0; i < 16; i++) m_a[i] = 32'd0;
    n = 0;
    for (int it = 0; it < 40; it++) begin
      if (a_busy !== 1'b1) break;
      n++;
      if (it == 2) begin
        a_rd_en = 2'b11; a_rd_addr = {4'd4, 4'd1};
      end else if (it == 3) begin
        a_rd_en = 2'b00;
        total++;
        if (a_rd_valid !== 2'b00 || a_rd_data !== {held_a[1], held_a[0]}) begin
          bad++; $display("FAIL busy_read: valid=%b data=%h expected 00/%h", a_rd_valid, a_rd_data,
                          {held_a[1], held_a[0]});
        end
      end else if (it == 5) begin
        a_clr = 1'b1;
      end else if (it == 6) begin
        a_clr = 1'b0;
      end else if (it == 10) begin
        a_wr_en = 1'b1; a_wr_addr = 4'd2; a_wr_data = 32'hFFFFFFFF; a_wr_be = 4'hF;
      end else if (it == 11) begin
        a_wr_en = 1'b0;
      end
      tick();
    end
    total++;
    if (n !== 16) begin bad++; $display("FAIL busy_len: got %0d cycles expected 16", n); end
    for (int i = 0; i <= 8; i++) begin
      while (q_a.size() > 0) begin
        e = q_a.pop_front(); total++;
        if (a_rd_valid[e.port] !== 1'b1 || a_rd_data[e.port*32 +: 32] !== e.data) begin
          bad++; $display("FAIL clear_read s%0d p%0d: valid=%b data=%h expected 1/%h", i, e.port,
                          a_rd_valid[e.port], a_rd_data[e.port*32 +: 32], e.data);
        end
        held_a[e.port] = e.data;
      end
      if (i < 8) begin
        a_rd_en = 2'b11; a_rd_addr = {4'(2*i+1), 4'(2*i)};
        q_a.push_back('{0, m_a[2*i]}); q_a.push_back('{1, m_a[2*i+1]});
        tick();
      end
    end
    a_rd_en = 2'b00;
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    int n;
    for (int i = 0; i < 16; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 4'(i); a_wr_data = 32'hC0DE0000 | 32'(i); a_wr_be = 4'hF;
      tick();
    end
    a_wr_en = 1'b0;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    repeat (4) tick();
    total++;
    if (a_busy !== 1'b1) begin bad++; $display("FAIL midclr_busy: got %b expected 1", a_busy); end
    rst = 1'b0;
    #1;
    total++;
    if (a_busy !== 1'b0 || a_rd_valid !== 2'b00 || a_rd_data !== 64'd0) begin
      bad++; $display("FAIL midclr_reset: busy=%b valid=%b data=%h expected 0", a_busy, a_rd_valid, a_rd_data);
    end
    #1 rst = 1'b1;
    for (int i = 0; i < 16; i++) m_a[i] = 32'd0;
    tick();
    for (int i = 0; i <= 8; i++) begin
      while (q_a.size() > 0) begin
        e = q_a.pop_front(); total++;
        if (a_rd_valid[e.port] !== 1'b1 || a_rd_data[e.port*32 +: 32] !== e.data) begin
          bad++; $display("FAIL midclr_read s%0d p%0d: valid=%b data=%h expected 1/%h", i, e.port,
                          a_rd_valid[e.port], a_rd_data[e.port*32 +: 32], e.data);
        end
      end
      if (i < 8) begin
        a_rd_en = 2'b11; a_rd_addr = {4'(2*i+1), 4'(2*i)};
        q_a.push_back('{0, m_a[2*i]}); q_a.push_back('{1, m_a[2*i+1]});
        tick();
      end
    end
    a_rd_en = 2'b00;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    n = 0;
    for (int it = 0; it < 40; it++) begin
      if (a_busy !== 1'b1) break;
      n++;
      tick();
    end
    total++;
    if (n !== 16) begin bad++; $display("FAIL reclear_len: got %0d cycles expected 16", n); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_byte_write();
    test_rdw();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file. It provides one byte-enabled write port, NRD independent registered read ports, and configurable read-during-write bypass. A sequenced clear engine zeroes the array on request. Unlike the single-port generation, reads and writes may occur in the same cycle.

Parameters:
WIDTH  32  data width in bits; must be a multiple of 8
DEPTH  16  number of entries, 2..256; need not be a power of 2
ADDR   4   address width; must satisfy 2**ADDR >= DEPTH
NRD    2   number of read ports, 1..4
BYPASS 1   1 = read-during-write to the same address returns new data; 0 = returns old data

Ports:
clk       in   1              clock
rst       in   1              reset, asynchronous, active-low
clr_req   in   1              one-cycle request to zero all entries
busy      out  1              clear sequence in progress
wr_en     in   1              write request
wr_addr   in   ADDR           write address
wr_data   in   WIDTH          write data
wr_be     in   WIDTH/8        byte enables; bit k covers bits [8k+7:8k]
rd_en     in   NRD            per-port read request
rd_addr   in   NRD*ADDR       packed read addresses; port i uses slice i
rd_data   out  NRD*WIDTH      packed registered read data
rd_valid  out  NRD            per-port one-cycle valid pulse
err       out  1              one-cycle pulse on any out-of-range access

Behaviour:
- Reset (rst low, asynchronous):
  - all entries 0; rd_data 0; rd_valid 0; err 0; busy 0
  - FSM to IDLE; clear counter 0
- FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR when clr_req=1.
  - In CLEAR, entry[cnt] <= 0 each cycle and cnt increments.
  - CLEAR -> IDLE in the cycle after the cycle writing entry DEPTH-1. The clear therefore takes exactly DEPTH cycles.
  - busy=1 for all DEPTH cycles, registered: it rises the cycle after clr_req.
  - clr_req while in CLEAR is ignored (no restart).
- While busy=1:
  - wr_en is dropped, with no later replay.
  - rd_en is ignored: rd_valid stays 0 and rd_data holds.
- Write, in IDLE with wr_en=1 and wr_addr < DEPTH:
  - at the clock edge, byte k of entry[wr_addr] <= wr_data byte k for every k with wr_be[k]=1
  - other bytes are unchanged
  - wr_be=0 is a legal no-op
- Read, port i, in IDLE with rd_en[i]=1:
  - latency 1: rd_data slice i <= entry[rd_addr_i] and rd_valid[i]=1 for one cycle
  - with rd_en[i]=0, rd_valid[i]=0 and rd_data slice i holds its last value
- Ports are independent. Any number of ports may read the same address in the same cycle, and all return identical data.
- Read-during-write, same address, same cycle:
  - BYPASS=1: the port returns the byte-merged new value (old bytes where wr_be=0, new bytes where wr_be=1)
  - BYPASS=0: the port returns the pre-write value
- Out of range (address >= DEPTH, possible only when DEPTH < 2**ADDR):
  - a write is ignored
  - a read returns 0 with rd_valid=1
  - err pulses high the next cycle for either case; it is the OR over all ports and the write port
- clr_req and wr_en in the same IDLE cycle: the write completes and the clear starts on the next cycle. The written entry is then zeroed by the clear.
- Reset asserted mid-CLEAR aborts the sequence. All state returns to reset values, so the array is zero either way.
- No combinational path exists from inputs to outputs.

Test Plan:
1. Reset, then NRD=2 reads of addresses 0 and 15 -> rd_valid=2'b11 one cycle later, both rd_data=0, err=0.
2. Write 0xDEADBEEF to addr 3 with wr_be=4'b1111, then write 0x11223344 to addr 3 with wr_be=4'b0101 -> a later read of addr 3 returns 0xDE22BE44 with latency 1.
3. Addr 5 holds 0xAAAAAAAA; same cycle: write 0x12345678 be=4'b0011 to addr 5, port 0 reads addr 5 -> BYPASS=1 gives 0xAAAA5678; BYPASS=0 gives 0xAAAAAAAA. The next read gives 0xAAAA5678 in both cases.
4. Fill all 16 entries with non-zero values, pulse clr_req -> busy high for exactly 16 cycles; a write to addr 2 during busy is dropped; reads return rd_valid=0 during busy. After busy falls, every address reads 0.
5. DEPTH=12, ADDR=4: write 0x5 to addr 13, then read addr 13 -> err pulses after each access; the read returns 0 with rd_valid=1; entries 0..11 are unchanged.
6. Assert rst at cycle 5 of a 16-cycle clear -> busy=0 immediately and all reads return 0. A subsequent clr_req runs a full 16-cycle sequence.
